// File: rtl/v_store_bank_wbuf.sv
// Write buffer between the vector store unit and four interleaved 32-bit data
// memory banks. It queues 4-lane store beats and steers each lane to bank
// addr[1:0] at row addr[MSB:2]. Lanes of one beat that collide on a bank are
// issued over several cycles in ascending lane order.
module v_store_bank_wbuf #(
  parameter int DATAMEM_BITS  = 14,
  parameter int DATAMEM_WIDTH = 32,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATAMEM_BITS-1:0]  in_addr0,
  input  logic [DATAMEM_BITS-1:0]  in_addr1,
  input  logic [DATAMEM_BITS-1:0]  in_addr2,
  input  logic [DATAMEM_BITS-1:0]  in_addr3,
  input  logic [DATAMEM_WIDTH-1:0] in_data0,
  input  logic [DATAMEM_WIDTH-1:0] in_data1,
  input  logic [DATAMEM_WIDTH-1:0] in_data2,
  input  logic [DATAMEM_WIDTH-1:0] in_data3,
  input  logic [3:0]               in_mask,
  output logic [3:0]               bank_we,
  output logic [DATAMEM_BITS-3:0]  bank_addr0,
  output logic [DATAMEM_BITS-3:0]  bank_addr1,
  output logic [DATAMEM_BITS-3:0]  bank_addr2,
  output logic [DATAMEM_BITS-3:0]  bank_addr3,
  output logic [DATAMEM_WIDTH-1:0] bank_wdata0,
  output logic [DATAMEM_WIDTH-1:0] bank_wdata1,
  output logic [DATAMEM_WIDTH-1:0] bank_wdata2,
  output logic [DATAMEM_WIDTH-1:0] bank_wdata3,
  output logic                     idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = DATAMEM_BITS - 2;

  // Beat storage: per-entry lane addresses, lane data and lane mask.
  logic [DATAMEM_BITS-1:0]  fifo_addr [DEPTH][4];
  logic [DATAMEM_WIDTH-1:0] fifo_data [DEPTH][4];
  logic [3:0]               fifo_mask [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Lanes of the head beat still waiting to issue; pend_valid is low while
  // the head has not issued anything yet, so its full mask applies.
  logic [3:0] pend;
  logic       pend_valid;

  logic [DATAMEM_BITS-1:0]  lane_addr [4];
  logic [DATAMEM_WIDTH-1:0] lane_data [4];
  logic [RW-1:0]            row_q     [4];
  logic [DATAMEM_WIDTH-1:0] wdata_q   [4];

  logic       empty;
  logic       push;
  logic       pop;
  logic [3:0] cur_pend;
  logic [3:0] issued;
  logic [3:0] remaining;
  logic [3:0] sel_valid;
  logic [1:0] sel_lane [4];

  assign lane_addr[0] = in_addr0;
  assign lane_addr[1] = in_addr1;
  assign lane_addr[2] = in_addr2;
  assign lane_addr[3] = in_addr3;
  assign lane_data[0] = in_data0;
  assign lane_data[1] = in_data1;
  assign lane_data[2] = in_data2;
  assign lane_data[3] = in_data3;

  assign empty     = (count == '0);
  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign cur_pend  = empty ? 4'b0000 : (pend_valid ? pend : fifo_mask[rd_ptr]);
  assign remaining = cur_pend & ~issued;
  assign pop       = !empty && (remaining == 4'b0000);
  assign idle      = empty && (bank_we == 4'b0000);

  // Per bank, pick the lowest-index pending lane of the head that maps to it.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    sel_valid = '0;
    issued    = '0;
    for (int b = 0; b < 4; b++) begin
      sel_lane[b] = '0;
      for (int i = 3; i >= 0; i--) begin
        if (cur_pend[i] && (fifo_addr[rd_ptr][i][1:0] == 2'(b))) begin
          sel_valid[b] = 1'b1;
          sel_lane[b]  = 2'(i);
        end
      end
      if (sel_valid[b]) issued[sel_lane[b]] = 1'b1;
    end
  end

  // Capture an accepted beat into the tail entry.
  // NOTE: the storage array has no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 4; i++) begin
        fifo_addr[wr_ptr][i] <= lane_addr[i];
        fifo_data[wr_ptr][i] <= lane_data[i];
      end
      fifo_mask[wr_ptr] <= in_mask;
    end
  end

  // FIFO pointers, occupancy and the head's pending-lane register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (pop) begin
        pend_valid <= 1'b0;
      end else if (!empty) begin
        pend       <= remaining;
        pend_valid <= 1'b1;
      end
    end
  end

  // Register the selected lanes onto the bank write ports; idle banks hold row/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_we <= '0;
      for (int b = 0; b < 4; b++) begin
        row_q[b]   <= '0;
        wdata_q[b] <= '0;
      end
    end else begin
      bank_we <= sel_valid;
      for (int b = 0; b < 4; b++) begin
        if (sel_valid[b]) begin
          row_q[b]   <= fifo_addr[rd_ptr][sel_lane[b]][DATAMEM_BITS-1:2];
          wdata_q[b] <= fifo_data[rd_ptr][sel_lane[b]];
        end
      end
    end
  end

  assign bank_addr0  = row_q[0];
  assign bank_addr1  = row_q[1];
  assign bank_addr2  = row_q[2];
  assign bank_addr3  = row_q[3];
  assign bank_wdata0 = wdata_q[0];
  assign bank_wdata1 = wdata_q[1];
  assign bank_wdata2 = wdata_q[2];
  assign bank_wdata3 = wdata_q[3];

endmodule

// File: tb/tb_v_store_bank_wbuf.sv
// Self-checking bench for v_store_bank_wbuf: directed vector table, hand-written
// multi-cycle sequences and randomized beats, all checked against a reference
// model that expands each beat into per-cycle bank writes and a word memory.
`timescale 1ns/1ps
module tb_v_store_bank_wbuf;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int RW = AW - 2;

  typedef logic [3:0][AW-1:0] addr4_t;
  typedef logic [3:0][DW-1:0] data4_t;

  typedef struct {
    logic [3:0]          we;
    logic [3:0][RW-1:0]  row;
    data4_t              data;
  } wr_t;

  typedef struct {
    addr4_t      addr;
    data4_t      data;
    logic [3:0]  mask;
    logic [3:0]  first_we;
    logic [RW-1:0] first_row0;
    int          busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic [AW-1:0] in_addr0, in_addr1, in_addr2, in_addr3;
  logic [DW-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_mask;
  logic [3:0] bank_we;
  logic [RW-1:0] bank_addr0, bank_addr1, bank_addr2, bank_addr3;
  logic [DW-1:0] bank_wdata0, bank_wdata1, bank_wdata2, bank_wdata3;
  logic idle;

  logic [RW-1:0] b_row [4];
  logic [DW-1:0] b_wd  [4];

  int checks = 0;
  int errors = 0;
  int lane_writes = 0;
  logic saw_full = 1'b0;

  wr_t exp_q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] dut_mem [0:(1<<AW)-1];
  vec_t vecs [7];

  always #5 clk = ~clk;

  v_store_bank_wbuf #(.DATAMEM_BITS(AW), .DATAMEM_WIDTH(DW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr0(in_addr0), .in_addr1(in_addr1), .in_addr2(in_addr2), .in_addr3(in_addr3),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_mask(in_mask), .bank_we(bank_we),
    .bank_addr0(bank_addr0), .bank_addr1(bank_addr1), .bank_addr2(bank_addr2), .bank_addr3(bank_addr3),
    .bank_wdata0(bank_wdata0), .bank_wdata1(bank_wdata1), .bank_wdata2(bank_wdata2), .bank_wdata3(bank_wdata3),
    .idle(idle)
  );

  assign b_row[0] = bank_addr0;
  assign b_row[1] = bank_addr1;
  assign b_row[2] = bank_addr2;
  assign b_row[3] = bank_addr3;
  assign b_wd[0]  = bank_wdata0;
  assign b_wd[1]  = bank_wdata1;
  assign b_wd[2]  = bank_wdata2;
  assign b_wd[3]  = bank_wdata3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic addr4_t stride(input int base, input int st);
    addr4_t a;
    for (int i = 0; i < 4; i++) a[i] = AW'(base + i * st);
    return a;
  endfunction

  function automatic vec_t mk(input addr4_t a, input data4_t d, input logic [3:0] m,
                              input logic [3:0] fw, input logic [RW-1:0] r0, input int busy);
    vec_t v;
    v.addr = a; v.data = d; v.mask = m;
    v.first_we = fw; v.first_row0 = r0; v.busy = busy;
    return v;
  endfunction

  // Reference: final memory is the lanes applied in order; the write stream has,
  // in cycle k, the k-th lane (in lane order) that maps to each bank.
  function automatic void model_push(input addr4_t a, input data4_t d, input logic [3:0] m);
    int cnt [4];
    int ncyc;
    int seen;
    wr_t w;
    ncyc = 0;
    for (int b = 0; b < 4; b++) cnt[b] = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        ref_mem[a[i]] = d[i];
        cnt[a[i] % 4]++;
      end
    end
    for (int b = 0; b < 4; b++) if (cnt[b] > ncyc) ncyc = cnt[b];
    for (int k = 0; k < ncyc; k++) begin
      w.we = '0; w.row = '0; w.data = '0;
      for (int b = 0; b < 4; b++) begin
        seen = 0;
        for (int i = 0; i < 4; i++) begin
          if (m[i] && (a[i] % 4 == b)) begin
            if (seen == k) begin
              w.we[b]   = 1'b1;
              w.row[b]  = RW'(a[i] / 4);
              w.data[b] = d[i];
            end
            seen++;
          end
        end
      end
      exp_q.push_back(w);
    end
  endfunction

  task automatic set_inputs(input addr4_t a, input data4_t d, input logic [3:0] m);
    in_addr0 = a[0]; in_addr1 = a[1]; in_addr2 = a[2]; in_addr3 = a[3];
    in_data0 = d[0]; in_data1 = d[1]; in_data2 = d[2]; in_data3 = d[3];
    in_mask  = m;
  endtask

  // Offer one beat until accepted (bounded); returns #1 after the accepting edge.
  task automatic send_beat(input addr4_t a, input data4_t d, input logic [3:0] m);
    logic acc;
    acc = 1'b0;
    set_inputs(a, d, m);
    in_valid = 1'b1;
    for (int c = 0; c < 200 && !acc; c++) begin
      acc = in_ready;
      if (!in_ready) saw_full = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("beat_accepted", acc, 1);
    if (acc) model_push(a, d, m);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!idle && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_to_idle", idle, 1);
  endtask

  // Compare every issued bank write against the reference stream and mirror it into dut_mem.
  always @(negedge clk) begin
    wr_t w;
    if (!rst && bank_we != 4'b0000) begin
      lane_writes += $countones(bank_we);
      for (int b = 0; b < 4; b++)
        if (bank_we[b]) dut_mem[{b_row[b], 2'(b)}] = b_wd[b];
      if (exp_q.size() == 0) begin
        check("unexpected_write", bank_we, 0);
      end else begin
        w = exp_q.pop_front();
        check("stream_we", bank_we, w.we);
        for (int b = 0; b < 4; b++) begin
          if (w.we[b] && bank_we[b]) begin
            check($sformatf("stream_row%0d", b), b_row[b], w.row[b]);
            check($sformatf("stream_data%0d", b), b_wd[b], w.data[b]);
          end
        end
      end
    end
  end

  initial begin
    addr4_t a;
    data4_t d;
    logic [3:0] m;
    int n;
    int wb;
    int st;

    for (int i = 0; i < (1<<AW); i++) begin
      ref_mem[i] = '0;
      dut_mem[i] = '0;
    end
    rst = 1'b1;
    in_valid = 1'b0;
    set_inputs('0, '0, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_we", bank_we, 4'b0000);
    check("reset_idle", idle, 1);
    check("reset_ready", in_ready, 1);
    check("reset_addr0", bank_addr0, 0);
    check("reset_wdata3", bank_wdata3, 0);

    // Directed vectors: first-cycle bank enables, bank0 row, cycles until idle.
    vecs[0] = mk(stride(14'h100, 1), {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'b1111, 4'b1111, 12'h040, 2);
    vecs[1] = mk(stride(14'h010, 4), {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'b1111, 4'b0001, 12'h004, 5);
    vecs[2] = mk(stride(14'h020, 0), {32'd4, 32'd3, 32'd2, 32'd1},     4'b1111, 4'b0001, 12'h008, 5);
    vecs[3] = mk(stride(14'h300, 1), {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 4'b0000, 4'b0000, 12'h000, 1);
    vecs[4] = mk(stride(14'h000, 2), {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 4'b1111, 4'b0101, 12'h000, 3);
    vecs[5] = mk(stride(14'h200, 1), {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 4'b1010, 4'b1010, 12'h000, 2);
    vecs[6] = mk(stride(14'h040, 4), {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 4'b0110, 4'b0001, 12'h011, 3);

    foreach (vecs[v]) begin
      send_beat(vecs[v].addr, vecs[v].data, vecs[v].mask);
      @(posedge clk); #1;
      n = 1;
      check($sformatf("vec%0d_first_we", v), bank_we, vecs[v].first_we);
      if (vecs[v].first_we[0]) check($sformatf("vec%0d_first_row0", v), bank_addr0, vecs[v].first_row0);
      while (!idle && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      check($sformatf("vec%0d_busy_cycles", v), n, vecs[v].busy);
    end
    check("same_addr_final_value", dut_mem[14'h020], 32'd4);

    // Zero-mask beat between two unit-stride beats, offered back to back.
    set_inputs(stride(14'h180, 1), {32'h13, 32'h12, 32'h11, 32'h10}, 4'b1111);
    in_valid = 1'b1;
    check("zm_ready0", in_ready, 1);
    @(posedge clk); #1;
    model_push(stride(14'h180, 1), {32'h13, 32'h12, 32'h11, 32'h10}, 4'b1111);
    set_inputs(stride(14'h190, 1), '0, 4'b0000);
    check("zm_ready1", in_ready, 1);
    @(posedge clk); #1;
    model_push(stride(14'h190, 1), '0, 4'b0000);
    check("zm_first_we", bank_we, 4'b1111);
    set_inputs(stride(14'h1A0, 1), {32'h23, 32'h22, 32'h21, 32'h20}, 4'b1111);
    check("zm_ready2", in_ready, 1);
    @(posedge clk); #1;
    model_push(stride(14'h1A0, 1), {32'h23, 32'h22, 32'h21, 32'h20}, 4'b1111);
    in_valid = 1'b0;
    check("zm_gap_we", bank_we, 4'b0000);
    @(posedge clk); #1;
    check("zm_last_we", bank_we, 4'b1111);
    check("zm_last_wdata2", bank_wdata2, 32'h22);
    wait_idle(20);

    // Backpressure: six stride-4 beats offered continuously.
    saw_full = 1'b0;
    wb = lane_writes;
    for (int k = 0; k < 6; k++)
      send_beat(stride(14'h400 + k * 16, 4), {DW'(k*4+3), DW'(k*4+2), DW'(k*4+1), DW'(k*4)}, 4'b1111);
    wait_idle(100);
    check("bp_saw_not_ready", saw_full, 1);
    check("bp_lane_writes", lane_writes - wb, 24);
    check("bp_stream_consumed", exp_q.size(), 0);

    // Reset mid-burst with three beats queued.
    for (int k = 0; k < 3; k++)
      send_beat(stride(14'h500 + k * 16, 4), {32'h5, 32'h6, 32'h7, 32'h8}, 4'b1111);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    wb = lane_writes;
    check("rst_we_c0", bank_we, 4'b0000);
    check("rst_idle", idle, 1);
    check("rst_ready", in_ready, 1);
    @(posedge clk); #1;
    check("rst_we_c1", bank_we, 4'b0000);
    repeat (6) @(posedge clk);
    #1;
    check("rst_no_more_writes", lane_writes - wb, 0);
    check("rst_still_idle", idle, 1);

    // Randomized beats over a small window to provoke conflicts.
    for (int i = 0; i < (1<<AW); i++) begin
      ref_mem[i] = '0;
      dut_mem[i] = '0;
    end
    for (int k = 0; k < 300; k++) begin
      st = $urandom_range(0, 3);
      n = $urandom_range(0, 63);
      for (int i = 0; i < 4; i++) begin
        case (st)
          0: a[i] = AW'((n + i) % 64);
          1: a[i] = AW'((n + 4 * i) % 64);
          2: a[i] = AW'(n);
          default: a[i] = AW'($urandom_range(0, 63));
        endcase
        d[i] = $urandom;
      end
      m = 4'($urandom_range(0, 15));
      send_beat(a, d, m);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
    end
    wait_idle(2000);
    check("rand_stream_consumed", exp_q.size(), 0);
    for (int i = 0; i < 64; i++)
      check($sformatf("rand_mem_%0d", i), dut_mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/v_store_bank_wbuf.md
Name: v_store_bank_wbuf

Overview:
- Write buffer sitting directly downstream of the vector store unit, in front of the four interleaved 32-bit data memory banks.
- Accepts one 4-lane store beat per handshake: four word addresses, four data words and a lane mask.
- Steers each lane to bank addr[1:0] at row addr[DATAMEM_BITS-1:2].
- Serializes bank conflicts produced by strided stores, so each bank sees at most one write per cycle and lane order is preserved.

Parameters:
DATAMEM_BITS, 14, word-address width (matches `DATAMEM_BITS)
DATAMEM_WIDTH, 32, bank data width
DEPTH, 4, beat FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
in_valid  in  1  store beat offered
in_ready  out  1  beat accepted when in_valid && in_ready
in_addr0..in_addr3  in  DATAMEM_BITS  per-lane word address
in_data0..in_data3  in  DATAMEM_WIDTH  per-lane store data
in_mask  in  4  lane enable, bit i = lane i
bank_we  out  4  bank i write enable
bank_addr0..bank_addr3  out  DATAMEM_BITS-2  bank row
bank_wdata0..bank_wdata3  out  DATAMEM_WIDTH  bank write data
idle  out  1  FIFO empty and bank_we==0

Behaviour:
- Reset: FIFO flushed (count=0, rd/wr pointers 0), pending-lane register cleared; bank_we=0, bank_addr*=0, bank_wdata*=0, in_ready=1, idle=1. Reset mid-operation discards all buffered and partially issued beats; no write is issued in the reset cycle or the cycle after.
- in_ready = (count < DEPTH), registered-count based; it does not depend on a same-cycle pop. Push when full is therefore impossible. Push and pop in the same cycle are allowed when not full; count is then unchanged.
- FIFO entry holds addr0..3, data0..3 and mask. Pointers wrap modulo DEPTH.
- Issue, evaluated on the head entry each cycle the FIFO is non-empty. `pend` holds the head's remaining lanes and is loaded from the entry mask when the entry becomes head.
  - For each bank b, select the lowest-index lane i in pend with addr_i[1:0]==b.
  - Selected lanes are registered at posedge into bank_we[b]=1, bank_addr_b=addr_i[DATAMEM_BITS-1:2], bank_wdata_b=data_i. Selected lanes are cleared from pend.
  - Unselected banks: bank_we[b]=0. bank_addr/bank_wdata hold their previous value.
- Ordering: two lanes of one beat hitting the same bank issue in ascending lane order on successive cycles, so a higher lane to the same address overwrites a lower one. Beats issue strictly in FIFO order; no lanes from two different beats are merged in one cycle.
- Pop: the head is popped at the posedge where all its remaining lanes issue. Zero-mask beats pop in one cycle with bank_we=0.
- Issue cycles per beat = max over banks of the number of lanes mapped to that bank (1..4); unit-stride beats take 1.
- Latency: beat accepted at edge t into an empty FIFO → first bank_we visible after edge t+1. Memory samples at edge t+2.
- Back-to-back unit-stride beats sustain 1 beat/cycle.
- Address arithmetic is the caller's; wrap at 2^DATAMEM_BITS is not checked.
- idle = (count==0) && (bank_we==0).

Test Plan:
- Reset mid-burst: 3 beats queued, assert rst one cycle → bank_we=0 for the next 2 cycles, idle=1, in_ready=1, no further writes.
- Unit-stride: addrs 0x100..0x103, data A0..A3, mask 1111 → one cycle later bank_we=1111, all bank_addr=0x40, wdata bank i = Ai; idle returns 1 the following cycle.
- Stride 4: addrs 0x10, 0x14, 0x18, 0x1C, mask 1111 → four consecutive cycles with bank_we=0001 and bank_addr0 = 0x4, 0x5, 0x6, 0x7 in lane order.
- Same-address conflict: all lanes addr 0x20, data 1, 2, 3, 4 → four writes to bank0 row 0x8 in order 1, 2, 3, 4; final memory value 4.
- Backpressure: DEPTH=4, offer 6 stride-4 beats continuously → in_ready=0 while count=4, no beat lost or duplicated, 24 writes in order.
- Mask 0000 beat between two unit-stride beats → popped in 1 cycle with no bank_we; neighbouring beats write correctly.
